// File: rtl/dac_pkg.sv
// dac_pkg: shared sizes, power-state encoding and unary clamp for the segmented DAC decoder
package dac_pkg;
  localparam int NUM_THERM = 17;
  localparam int BIN_W     = 6;
  localparam int CODE_W    = 11;
  localparam int M_W       = CODE_W - BIN_W;
  typedef enum logic [1:0] {OFF, SETTLE, RUN} dac_pwr_state_e;
  // The spare unary cell caps the reachable count at NUM_THERM-1.
  function automatic logic [M_W-1:0] sat_unary(input logic [M_W-1:0] m);
    return (m > M_W'(NUM_THERM - 1)) ? M_W'(NUM_THERM - 1) : m;
  endfunction
endpackage

// File: rtl/dac_dwa_rotator.sv
// dac_dwa_rotator: m-cell wide unary mask starting at ptr, wrapping modulo NUM_THERM
module dac_dwa_rotator
  import dac_pkg::*;
(
  input  logic [M_W-1:0]       m,
  input  logic [M_W-1:0]       ptr,
  output logic [NUM_THERM-1:0] mask,
  output logic [M_W-1:0]       ptr_next
);
  logic [5:0] sum;
  assign sum      = {1'b0, ptr} + {1'b0, m};
  assign ptr_next = (sum >= 6'(NUM_THERM)) ? M_W'(sum - 6'(NUM_THERM)) : sum[M_W-1:0];
  for (genvar i = 0; i < NUM_THERM; i++) begin : g_cell
    logic [5:0] off;
    // Distance of cell i past ptr around the ring; the cell is on when it falls inside m.
    assign off     = 6'(i) + 6'(NUM_THERM) - {1'b0, ptr};
    assign mask[i] = ((off >= 6'(NUM_THERM)) ? off - 6'(NUM_THERM) : off) < {1'b0, m};
  end
endmodule

// File: rtl/dac_segment_decoder.sv
// dac_segment_decoder: binary code to rotated unary + binary cell selects, gated by power-up sequencing
module dac_segment_decoder
  import dac_pkg::*;
#(
  parameter int SETTLE_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 pdb,
  input  logic                 dem_ena,
  input  logic                 red_ena,
  input  logic [CODE_W-1:0]    code,
  input  logic                 code_valid,
  output logic                 code_ready,
  output logic [NUM_THERM-1:0] therm_sel,
  output logic [BIN_W-1:0]     bin_sel,
  output logic                 bin_red_sel,
  output logic                 sat,
  output logic                 settled
);
  dac_pwr_state_e       state, state_nxt;
  logic [9:0]           cnt;
  logic [M_W-1:0]       ptr, ptr_nxt, m_raw, m;
  logic                 over, accept;
  logic [BIN_W-1:0]     bin;
  logic [NUM_THERM-1:0] mask;

  assign code_ready = (state == RUN);
  assign settled    = (state == RUN);
  assign accept     = code_valid && code_ready;
  assign m_raw      = code[CODE_W-1:BIN_W];
  assign m          = sat_unary(m_raw);
  assign over       = m_raw > M_W'(NUM_THERM - 1);
  assign bin        = over ? '1 : code[BIN_W-1:0];

  // Fixed fill is the same ring walk anchored at cell 0.
  dac_dwa_rotator u_rot (
    .m        (m),
    .ptr      (dem_ena ? ptr : '0),
    .mask     (mask),
    .ptr_next (ptr_nxt)
  );

  always_comb begin
    state_nxt = !pdb ? OFF :
                (state == OFF) ? SETTLE :
                (state == SETTLE && cnt == 10'(SETTLE_CYC - 1)) ? RUN : state;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == SETTLE && pdb) ? cnt + 10'd1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      therm_sel   <= '0;
      bin_sel     <= '0;
      bin_red_sel <= 1'b0;
      sat         <= 1'b0;
      ptr         <= '0;
    end else if (!pdb) begin
      therm_sel   <= '0;
      bin_sel     <= '0;
      bin_red_sel <= 1'b0;
      sat         <= 1'b0;
      ptr         <= '0;
    end else if (accept) begin
      therm_sel   <= mask;
      bin_sel     <= bin;
      bin_red_sel <= bin[0] & red_ena;
      sat         <= over;
      if (dem_ena) ptr <= ptr_nxt;
    end
  end
endmodule

// File: tb/tb_dac_segment_decoder.sv
// tb_dac_segment_decoder: directed and random checks of the segment decoder against a ring-walk model
module tb_dac_segment_decoder;
  import dac_pkg::*;
  localparam int SC = 64;

  logic                 clk = 0, rstb = 0, pdb = 0, dem_ena = 0, red_ena = 0, code_valid = 0;
  logic [CODE_W-1:0]    code = '0;
  logic                 code_ready, bin_red_sel, sat, settled;
  logic [NUM_THERM-1:0] therm_sel;
  logic [BIN_W-1:0]     bin_sel;

  int tests = 0, fails = 0;
  logic [16:0] e_therm = '0;
  logic [5:0]  e_bin = '0;
  logic        e_red = 0, e_sat = 0;
  int          e_ptr = 0, e_m = 0;

  always #5 clk = ~clk;

  dac_segment_decoder #(.SETTLE_CYC(SC)) dut (
    .clk(clk), .rstb(rstb), .pdb(pdb), .dem_ena(dem_ena), .red_ena(red_ena),
    .code(code), .code_valid(code_valid), .code_ready(code_ready),
    .therm_sel(therm_sel), .bin_sel(bin_sel), .bin_red_sel(bin_red_sel),
    .sat(sat), .settled(settled)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".therm"}, 32'(therm_sel), 32'(e_therm));
    chk({tag, ".bin"},   32'(bin_sel),   32'(e_bin));
    chk({tag, ".red"},   32'(bin_red_sel), 32'(e_red));
    chk({tag, ".sat"},   32'(sat),       32'(e_sat));
  endtask

  task automatic clear_model;
    e_therm = '0; e_bin = '0; e_red = 0; e_sat = 0; e_ptr = 0;
  endtask

  // Model: m cells lit walking around a 17-cell ring from the pointer (or cell 0).
  task automatic model_accept(input logic [10:0] c, input logic dem, input logic red);
    int m, b, base;
    m = int'(c) / 64;
    b = int'(c) % 64;
    e_sat = 0;
    if (m > 16) begin m = 16; b = 63; e_sat = 1; end
    base = dem ? e_ptr : 0;
    e_therm = '0;
    for (int k = 0; k < m; k++) e_therm[(base + k) % 17] = 1'b1;
    if (dem) e_ptr = (e_ptr + m) % 17;
    e_bin = 6'(b);
    e_red = (b % 2 == 1) && red;
    e_m = m;
  endtask

  task automatic step(input string tag, input logic v, input logic [10:0] c,
                      input logic dem, input logic red);
    @(negedge clk);
    code_valid = v; code = c; dem_ena = dem; red_ena = red;
    tick;
    if (v) model_accept(c, dem, red);
    check_all(tag);
    if (v) chk({tag, ".popcount"}, 32'($countones(therm_sel)), 32'(e_m));
  endtask

  task automatic power_up(input string tag);
    for (int c = 1; c <= SC + 1; c++) begin
      tick;
      chk({tag, ".settled"}, 32'(settled), 32'(c == SC + 1));
      chk({tag, ".ready"}, 32'(code_ready), 32'(c == SC + 1));
      chk({tag, ".therm0"}, 32'(therm_sel), 32'(0));
      chk({tag, ".bin0"}, 32'(bin_sel), 32'(0));
    end
  endtask

  initial begin
    tick;
    tick;
    check_all("reset");
    chk("reset.ready", 32'(code_ready), 0);
    chk("reset.settled", 32'(settled), 0);

    for (int v = 0; v < 32; v++)
      chk("sat_unary", 32'(sat_unary(5'(v))), 32'(v > 16 ? 16 : v));

    // pdb is sampled on the first edge; RUN follows SETTLE_CYC edges later. A code offered meanwhile is ignored.
    @(negedge clk);
    rstb = 1; pdb = 1; code_valid = 1; code = 11'h7C5;
    power_up("pwrup");

    step("fixed", 1, 11'h0C5, 0, 0);
    chk("fixed.const", 32'(therm_sel), 32'h00007);
    chk("fixed.bin_const", 32'(bin_sel), 32'h05);
    step("hold", 0, 11'h7FF, 1, 1);
    step("dwa15", 1, 11'h3C0, 1, 0);
    step("dwa_wrap", 1, 11'h100, 1, 0);
    chk("dwa_wrap.const", 32'(therm_sel), 32'h18003);
    step("dwa_ptr2", 1, 11'h040, 1, 0);
    chk("dwa_ptr2.const", 32'(therm_sel), 32'h00004);
    step("sat", 1, 11'h7FF, 0, 0);
    chk("sat.const", 32'(therm_sel), 32'h0FFFF);
    chk("sat.bin_const", 32'(bin_sel), 32'h3F);
    chk("sat.flag_const", 32'(sat), 1);
    step("m0", 1, 11'h015, 1, 1);
    step("frozen", 1, 11'h080, 0, 0);
    step("after_freeze", 1, 11'h080, 1, 0);
    step("red_on", 1, 11'h001, 0, 1);
    chk("red_on.const", 32'(bin_red_sel), 1);
    step("red_off", 1, 11'h001, 0, 0);
    chk("red_off.const", 32'(bin_red_sel), 0);

    for (int n = 0; n < 400; n++)
      step("rand", $urandom_range(0, 3) != 0, 11'($urandom), 1'($urandom), 1'($urandom));

    // Power-down during a valid burst: the code on the pdb=0 cycle is dropped.
    @(negedge clk);
    pdb = 0; code_valid = 1; code = 11'h2AB; dem_ena = 1;
    tick;
    clear_model();
    check_all("pdn");
    chk("pdn.ready", 32'(code_ready), 0);
    chk("pdn.settled", 32'(settled), 0);
    tick;
    check_all("pdn_hold");

    // Abort a power-up partway; the retry must wait the full count.
    @(negedge clk);
    pdb = 1;
    for (int c = 0; c < 20; c++) tick;
    chk("abort.settled", 32'(settled), 0);
    @(negedge clk);
    pdb = 0;
    tick;
    @(negedge clk);
    pdb = 1;
    power_up("repwr");
    step("ptr_cleared", 1, 11'h080, 1, 0);
    chk("ptr_cleared.const", 32'(therm_sel), 32'h00003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
